alarm_unit: RTL and testbench

//  Alarm stage downstream of the 12-hour BCD time counters (hours tens/units, minutes tens/units, AM/PM).

---
 rtl/alarm_unit.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_unit.sv
// Alarm stage for the 12-hour BCD clock: settable alarm time, match detection,
// ring/snooze/stop FSM paced by the 1 Hz tick, and debounced active-low keys.
module alarm_unit #(
    parameter int DEB_CYCLES  = 16,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_1hz,
    input  logic       qh1,
    input  logic [3:0] qh0,
    input  logic [3:0] qm1,
    input  logic [3:0] qm0,
    input  logic       qpm,
    input  logic       key_set_n,
    input  logic       key_inc_n,
    input  logic       key_off_n,
    output logic [1:0] set_mode,
    output logic       ah1,
    output logic [3:0] ah0,
    output logic [3:0] am1,
    output logic [3:0] am0,
    output logic       apm,
    output logic       alarm_on,
    output logic       buzzer
);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZE   = 2'b11
    } alarm_t;

    localparam logic [15:0] DEB_LAST    = 16'(DEB_CYCLES - 1);
    localparam logic [8:0]  RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0]  SNOOZE_LAST = 9'(SNOOZE_SECS - 1);

    logic [2:0]  keys;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  stable;
    logic [2:0]  press;
    logic [15:0] deb_cnt [3];

    mode_t       mode;
    alarm_t      state;
    logic [8:0]  ring_cnt;
    logic [8:0]  snz_cnt;
    logic        match;
    logic        match_q;
    logic        trigger;
    logic        p_set;
    logic        p_inc;
    logic        p_off;

    assign keys  = {key_off_n, key_inc_n, key_set_n};
    assign p_set = press[0];
    assign p_inc = press[1];
    assign p_off = press[2];

    // Keys idle high, so the debounce history resets to the released level.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1  <= 3'b111;
            sync2  <= 3'b111;
            stable <= 3'b111;
            press  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= 16'd0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= 16'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= 16'd0;
                    stable[i]  <= sync2[i];
                    press[i]   <= ~sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign match   = ({qh1, qh0, qm1, qm0, qpm} == {ah1, ah0, am1, am0, apm})
                     && (mode == NORMAL);
    assign trigger = match && !match_q;

    // One else-if chain gives the set > off > inc > tick/trigger priority.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mode     <= NORMAL;
            state    <= DISARMED;
            ah1      <= 1'b0;
            ah0      <= 4'd6;
            am1      <= 4'd0;
            am0      <= 4'd0;
            apm      <= 1'b0;
            ring_cnt <= 9'd0;
            snz_cnt  <= 9'd0;
            match_q  <= 1'b0;
        end else begin
            match_q <= match;
            if (p_set) begin
                case (mode)
                    NORMAL: begin
                        mode <= SET_HOUR;
                        if (state == RINGING || state == SNOOZE) begin
                            state <= ARMED;
                        end
                    end
                    SET_HOUR: mode <= SET_MIN;
                    default:  mode <= NORMAL;
                endcase
            end else if (mode == SET_HOUR) begin
                if (p_inc) begin
                    if (ah1 && ah0 == 4'd2) begin
                        ah1 <= 1'b0;
                        ah0 <= 4'd1;
                    end else if (ah1 && ah0 == 4'd1) begin
                        ah0 <= 4'd2;
                        apm <= ~apm;
                    end else if (ah0 == 4'd9) begin
                        ah1 <= 1'b1;
                        ah0 <= 4'd0;
                    end else begin
                        ah0 <= ah0 + 4'd1;
                    end
                end
            end else if (mode == SET_MIN) begin
                if (p_inc) begin
                    if (am0 == 4'd9) begin
                        am0 <= 4'd0;
                        am1 <= (am1 == 4'd5) ? 4'd0 : am1 + 4'd1;
                    end else begin
                        am0 <= am0 + 4'd1;
                    end
                end
            end else begin
                case (state)
                    DISARMED: begin
                        if (p_off) state <= ARMED;
                    end
                    ARMED: begin
                        if (p_off) begin
                            state <= DISARMED;
                        end else if (trigger) begin
                            state    <= RINGING;
                            ring_cnt <= 9'd0;
                        end
                    end
                    RINGING: begin
                        if (p_off) begin
                            state <= ARMED;
                        end else if (p_inc) begin
                            state   <= SNOOZE;
                            snz_cnt <= 9'd0;
                        end else if (tick_1hz) begin
                            if (ring_cnt == RING_LAST) begin
                                state <= ARMED;
                            end else begin
                                ring_cnt <= ring_cnt + 9'd1;
                            end
                        end
                    end
                    default: begin
                        if (p_off) begin
                            state <= ARMED;
                        end else if (p_inc) begin
                            state <= SNOOZE;
                        end else if (tick_1hz) begin
                            if (snz_cnt == SNOOZE_LAST) begin
                                state    <= RINGING;
                                ring_cnt <= 9'd0;
                            end else begin
                                snz_cnt <= snz_cnt + 9'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign set_mode = mode;
    assign alarm_on = (state != DISARMED);
    assign buzzer   = (state == RINGING);

endmodule

// File: tb/tb_alarm_unit.sv
// Directed testbench for alarm_unit: keys, set mode, ring, snooze, stop and reset.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick_1hz;
    logic       qh1;
    logic [3:0] qh0;
    logic [3:0] qm1;
    logic [3:0] qm0;
    logic       qpm;
    logic       key_set_n;
    logic       key_inc_n;
    logic       key_off_n;
    logic [1:0] set_mode;
    logic       ah1;
    logic [3:0] ah0;
    logic [3:0] am1;
    logic [3:0] am0;
    logic       apm;
    logic       alarm_on;
    logic       buzzer;
    logic [13:0] alarm_vec;

    int n_checks = 0;
    int n_fails  = 0;

    assign alarm_vec = {ah1, ah0, am1, am0, apm};

    alarm_unit #(
        .DEB_CYCLES (4),
        .RING_SECS  (3),
        .SNOOZE_SECS(2)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .tick_1hz (tick_1hz),
        .qh1      (qh1),
        .qh0      (qh0),
        .qm1      (qm1),
        .qm0      (qm0),
        .qpm      (qpm),
        .key_set_n(key_set_n),
        .key_inc_n(key_inc_n),
        .key_off_n(key_off_n),
        .set_mode (set_mode),
        .ah1      (ah1),
        .ah0      (ah0),
        .am1      (am1),
        .am0      (am0),
        .apm      (apm),
        .alarm_on (alarm_on),
        .buzzer   (buzzer)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_time(input logic h1, input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0, input logic pm);
        qh1 = h1;
        qh0 = h0;
        qm1 = m1;
        qm0 = m0;
        qpm = pm;
    endtask

    // k: 0 = set, 1 = inc, 2 = off, 3 = off and inc together
    task automatic press_key(input int k);
        case (k)
            0: key_set_n = 1'b0;
            1: key_inc_n = 1'b0;
            2: key_off_n = 1'b0;
            default: begin
                key_off_n = 1'b0;
                key_inc_n = 1'b0;
            end
        endcase
        wait_clks(10);
        key_set_n = 1'b1;
        key_inc_n = 1'b1;
        key_off_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic tick_once();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_clks(1);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        wait_clks(2);
    endtask

    task automatic retrigger();
        drive_time(1'b0, 4'd6, 4'd0, 4'd1, 1'b0);
        wait_clks(2);
        drive_time(1'b0, 4'd6, 4'd0, 4'd0, 1'b0);
        wait_clks(1);
    endtask

    task automatic test_reset();
        #2 clr = 1'b0;
        #1;
        n_checks++; if (set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_mode: got %b want 00", set_mode); end
        n_checks++; if (alarm_vec !== 14'b0_0110_0000_0000_0) begin n_fails++; $display("[TB] FAIL reset_alarm: got %b want 00110000000000", alarm_vec); end
        n_checks++; if (alarm_on !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_alarm_on: got %b want 0", alarm_on); end
        n_checks++; if (buzzer !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_buzzer: got %b want 0", buzzer); end
        @(negedge clk);
        clr = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 10; i++) begin
            key_set_n = ~key_set_n;
            @(negedge clk);
        end
        key_set_n = 1'b0;
        wait_clks(8);
        n_checks++; if (set_mode !== 2'b01) begin n_fails++; $display("[TB] FAIL deb_one_press: got %b want 01", set_mode); end
        wait_clks(12);
        n_checks++; if (set_mode !== 2'b01) begin n_fails++; $display("[TB] FAIL deb_hold: got %b want 01", set_mode); end
        key_set_n = 1'b1;
        wait_clks(10);
        key_set_n = 1'b0;
        wait_clks(3);
        key_set_n = 1'b1;
        wait_clks(10);
        n_checks++; if (set_mode !== 2'b01) begin n_fails++; $display("[TB] FAIL deb_short_hold: got %b want 01", set_mode); end
        press_key(0);
        n_checks++; if (set_mode !== 2'b10) begin n_fails++; $display("[TB] FAIL deb_to_set_min: got %b want 10", set_mode); end
        press_key(0);
        n_checks++; if (set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL deb_to_normal: got %b want 00", set_mode); end
    endtask

    task automatic test_set();
        press_key(0);
        repeat (3) press_key(1);
        press_key(0);
        repeat (2) press_key(1);
        press_key(0);
        n_checks++; if (alarm_vec !== 14'b0_1001_0000_0010_0) begin n_fails++; $display("[TB] FAIL set_0902: got %b want 01001000000100", alarm_vec); end
        n_checks++; if (set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL set_back_normal: got %b want 00", set_mode); end
        press_key(0);
        repeat (2) press_key(1);
        n_checks++; if (alarm_vec !== 14'b1_0001_0000_0010_0) begin n_fails++; $display("[TB] FAIL set_11am: got %b want 10001000000100", alarm_vec); end
        press_key(1);
        n_checks++; if (alarm_vec !== 14'b1_0010_0000_0010_1) begin n_fails++; $display("[TB] FAIL set_12pm: got %b want 10010000000101", alarm_vec); end
        press_key(1);
        n_checks++; if (alarm_vec !== 14'b0_0001_0000_0010_1) begin n_fails++; $display("[TB] FAIL set_01pm: got %b want 00001000000101", alarm_vec); end
        press_key(0);
        n_checks++; if (set_mode !== 2'b10) begin n_fails++; $display("[TB] FAIL set_min_mode: got %b want 10", set_mode); end
        repeat (57) press_key(1);
        n_checks++; if (alarm_vec !== 14'b0_0001_0101_1001_1) begin n_fails++; $display("[TB] FAIL set_min_59: got %b want 00001010110011", alarm_vec); end
        press_key(1);
        n_checks++; if (alarm_vec !== 14'b0_0001_0000_0000_1) begin n_fails++; $display("[TB] FAIL set_min_wrap: got %b want 00001000000001", alarm_vec); end
        press_key(0);
        n_checks++; if (set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL set_min_exit: got %b want 00", set_mode); end
    endtask

    task automatic test_ring();
        do_reset();
        drive_time(1'b0, 4'd1, 4'd2, 4'd3, 1'b1);
        wait_clks(2);
        press_key(2);
        n_checks++; if (alarm_on !== 1'b1 || buzzer !== 1'b0) begin n_fails++; $display("[TB] FAIL arm: alarm_on=%b buzzer=%b want 1 0", alarm_on, buzzer); end
        drive_time(1'b0, 4'd6, 4'd0, 4'd0, 1'b0);
        #1;
        n_checks++; if (buzzer !== 1'b0) begin n_fails++; $display("[TB] FAIL ring_not_early: got %b want 0", buzzer); end
        wait_clks(1);
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_latency: got %b want 1", buzzer); end
        tick_once();
        tick_once();
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_two_ticks: got %b want 1", buzzer); end
        tick_once();
        n_checks++; if (buzzer !== 1'b0 || alarm_on !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_timeout: buzzer=%b alarm_on=%b want 0 1", buzzer, alarm_on); end
        wait_clks(5);
        n_checks++; if (buzzer !== 1'b0) begin n_fails++; $display("[TB] FAIL no_retrigger: got %b want 0", buzzer); end
        retrigger();
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL retrigger: got %b want 1", buzzer); end
    endtask

    task automatic test_snooze();
        press_key(1);
        n_checks++; if (buzzer !== 1'b0 || alarm_on !== 1'b1) begin n_fails++; $display("[TB] FAIL snooze_enter: buzzer=%b alarm_on=%b want 0 1", buzzer, alarm_on); end
        tick_once();
        n_checks++; if (buzzer !== 1'b0) begin n_fails++; $display("[TB] FAIL snooze_one_tick: got %b want 0", buzzer); end
        tick_once();
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL snooze_rering: got %b want 1", buzzer); end
        press_key(2);
        n_checks++; if (buzzer !== 1'b0 || alarm_on !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_stop: buzzer=%b alarm_on=%b want 0 1", buzzer, alarm_on); end
        retrigger();
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_again: got %b want 1", buzzer); end
        press_key(3);
        tick_once();
        tick_once();
        n_checks++; if (buzzer !== 1'b0 || alarm_on !== 1'b1) begin n_fails++; $display("[TB] FAIL off_beats_inc: buzzer=%b alarm_on=%b want 0 1", buzzer, alarm_on); end
    endtask

    task automatic test_set_exit_and_clr();
        retrigger();
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL exit_pre_ring: got %b want 1", buzzer); end
        press_key(0);
        n_checks++; if (set_mode !== 2'b01 || buzzer !== 1'b0 || alarm_on !== 1'b1) begin n_fails++; $display("[TB] FAIL set_forces_armed: mode=%b buzzer=%b alarm_on=%b want 01 0 1", set_mode, buzzer, alarm_on); end
        press_key(1);
        press_key(0);
        press_key(0);
        n_checks++; if (alarm_vec !== 14'b0_0111_0000_0000_0 || set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL set_0700: alarm=%b mode=%b want 00111000000000 00", alarm_vec, set_mode); end
        drive_time(1'b0, 4'd7, 4'd0, 4'd0, 1'b0);
        wait_clks(1);
        n_checks++; if (buzzer !== 1'b1) begin n_fails++; $display("[TB] FAIL ring_0700: got %b want 1", buzzer); end
        #2 clr = 1'b0;
        #1;
        n_checks++; if (buzzer !== 1'b0 || alarm_on !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_mid_ring: buzzer=%b alarm_on=%b want 0 0", buzzer, alarm_on); end
        n_checks++; if (alarm_vec !== 14'b0_0110_0000_0000_0 || set_mode !== 2'b00) begin n_fails++; $display("[TB] FAIL clr_alarm: alarm=%b mode=%b want 00110000000000 00", alarm_vec, set_mode); end
        @(negedge clk);
        clr = 1'b1;
        wait_clks(2);
    endtask

    initial begin
        clr       = 1'b1;
        tick_1hz  = 1'b0;
        key_set_n = 1'b1;
        key_inc_n = 1'b1;
        key_off_n = 1'b1;
        drive_time(1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
        test_reset();
        test_debounce();
        test_set();
        test_ring();
        test_snooze();
        test_set_exit_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: still running at %0t, want finished", $time);
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
